fc_layer_ctrl: RTL and testbench

//  Sequencer for the fully-connected layer. On start, walks N_OUT output neurons.
//  For each neuron it clears the accumulator, issues N_IN feature/weight address

---
 rtl/fc_layer_ctrl.sv | 106 ++++++++++
 tb/tb_fc_layer_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_ctrl.sv
// fc_layer_ctrl: fully-connected layer sequencer driving feature/weight addresses,
// MAC accumulate control and score-buffer writes for N_OUT neurons of N_IN inputs.
module fc_layer_ctrl #(
  parameter int N_IN = 28,
  parameter int N_OUT = 10,
  parameter int MAC_LAT = 2,
  localparam int IN_W = $clog2(N_IN),
  localparam int OUT_W = $clog2(N_OUT),
  localparam int WA_W = $clog2(N_IN * N_OUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic [IN_W-1:0]  feat_addr,
  output logic [WA_W-1:0]  wgt_addr,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             out_we,
  output logic [OUT_W-1:0] out_addr,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, WR, FIN} state_t;
  localparam logic [MAC_LAT-1:0] SR_TOP = MAC_LAT'(1) << (MAC_LAT - 1);
  state_t state, state_d;
  logic [IN_W-1:0] feat_d;
  logic [WA_W-1:0] wgt_d;
  logic [OUT_W-1:0] neuron, neuron_d, out_addr_d;
  logic [MAC_LAT-1:0] sr, sr_d;
  logic issue, last_feat, last_wgt, last_neuron, pending;
  assign issue = state == RUN && in_valid;
  assign last_feat = feat_addr == IN_W'(N_IN - 1);
  assign last_wgt = wgt_addr == WA_W'(N_IN * N_OUT - 1);
  assign last_neuron = neuron == OUT_W'(N_OUT - 1);
  // the top bit fires this cycle; anything below it is still in flight
  assign pending = |(sr & ~SR_TOP);
  assign acc_en = sr[MAC_LAT-1];
  always_comb begin
    state_d = state;
    feat_d = feat_addr;
    wgt_d = wgt_addr;
    neuron_d = neuron;
    out_addr_d = out_addr;
    sr_d = MAC_LAT'({sr, issue});
    case (state)
      IDLE: if (start) begin
        state_d = CLR;
        neuron_d = '0;
        wgt_d = '0;
      end
      CLR: begin
        feat_d = '0;
        state_d = RUN;
      end
      RUN: if (issue) begin
        state_d = last_feat ? DRAIN : RUN;
        feat_d = last_feat ? feat_addr : feat_addr + IN_W'(1);
        wgt_d = last_wgt ? wgt_addr : wgt_addr + WA_W'(1);
      end
      DRAIN: if (!pending) begin
        state_d = WR;
        out_addr_d = neuron;
      end
      WR: begin
        state_d = last_neuron ? FIN : CLR;
        neuron_d = last_neuron ? neuron : neuron + OUT_W'(1);
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      sr_d = '0;
      feat_d = '0;
      wgt_d = '0;
      neuron_d = '0;
      out_addr_d = '0;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      feat_addr <= '0;
      wgt_addr <= '0;
      neuron <= '0;
      out_addr <= '0;
      sr <= '0;
      acc_clr <= 1'b0;
      out_we <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      feat_addr <= feat_d;
      wgt_addr <= wgt_d;
      neuron <= neuron_d;
      out_addr <= out_addr_d;
      sr <= sr_d;
      acc_clr <= state_d == CLR;
      out_we <= state_d == WR;
      busy <= state_d != IDLE;
      done <= state_d == FIN;
    end
endmodule

// File: tb/tb_fc_layer_ctrl.sv
// tb_fc_layer_ctrl: schedule-based reference model plus scenario table and hand-written
// abort/reset sequences for the FC layer sequencer (default and a small configuration).
module tb_fc_layer_ctrl;
  localparam int MAXC = 2000;
  logic clk = 0, reset = 0, abort = 0, in_valid = 0, start_a = 0, start_b = 0;
  logic [4:0] feat_a;
  logic [8:0] wgt_a;
  logic [3:0] oaddr_a;
  logic clr_a, acc_a, we_a, busy_a, done_a;
  logic [1:0] feat_b;
  logic [2:0] wgt_b;
  logic [0:0] oaddr_b;
  logic clr_b, acc_b, we_b, busy_b, done_b;
  int sel = 0, cyc = 0, checks = 0, errors = 0;
  int o_feat, o_wgt, o_oaddr, o_clr, o_acc, o_we, o_busy, o_done;
  bit iv[MAXC];
  bit sp[MAXC];
  int e_clr[MAXC], e_acc[MAXC], e_we[MAXC], e_oaddr[MAXC], e_busy[MAXC], e_done[MAXC];
  int e_chk[MAXC], e_feat[MAXC], e_wgt[MAXC];
  typedef struct {int sel; int stall_at; int stall_len; int pct; int repulse; int done_at;} vec_t;
  vec_t tbl[8];

  fc_layer_ctrl dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort), .in_valid(in_valid),
    .feat_addr(feat_a), .wgt_addr(wgt_a), .acc_clr(clr_a), .acc_en(acc_a), .out_we(we_a),
    .out_addr(oaddr_a), .busy(busy_a), .done(done_a));
  fc_layer_ctrl #(.N_IN(4), .N_OUT(2), .MAC_LAT(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort), .in_valid(in_valid),
    .feat_addr(feat_b), .wgt_addr(wgt_b), .acc_clr(clr_b), .acc_en(acc_b), .out_we(we_b),
    .out_addr(oaddr_b), .busy(busy_b), .done(done_b));

  assign o_feat = sel != 0 ? int'(feat_b) : int'(feat_a);
  assign o_wgt = sel != 0 ? int'(wgt_b) : int'(wgt_a);
  assign o_oaddr = sel != 0 ? int'(oaddr_b) : int'(oaddr_a);
  assign o_clr = sel != 0 ? int'(clr_b) : int'(clr_a);
  assign o_acc = sel != 0 ? int'(acc_b) : int'(acc_a);
  assign o_we = sel != 0 ? int'(we_b) : int'(we_a);
  assign o_busy = sel != 0 ? int'(busy_b) : int'(busy_a);
  assign o_done = sel != 0 ? int'(done_b) : int'(done_a);

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s (dut %0d, cycle %0d): got %0d, expected %0d", nm, sel, cyc, act, exp);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel != 0) start_b = v;
    else start_a = v;
  endtask

  // Timeline model: each neuron is one clear cycle, one cycle per input element plus one
  // per stalled cycle, MAC_LAT drain cycles and one write cycle; done follows the last write.
  function automatic int model(input int nin, input int nout, input int lat);
    int t;
    for (int c = 0; c < MAXC; c++) begin
      e_clr[c] = 0; e_acc[c] = 0; e_we[c] = 0; e_oaddr[c] = 0; e_busy[c] = 0;
      e_done[c] = 0; e_chk[c] = 0; e_feat[c] = 0; e_wgt[c] = 0;
    end
    t = 1;
    for (int n = 0; n < nout; n++) begin
      if (t > MAXC - 100) return -1;
      e_clr[t] = 1; e_busy[t] = 1; t++;
      for (int i = 0; i < nin; i++) begin
        while (1) begin
          e_busy[t] = 1; e_chk[t] = 1; e_feat[t] = i; e_wgt[t] = n * nin + i;
          if (iv[t] || t > MAXC - 100) break;
          t++;
        end
        e_acc[t + lat] = 1;
        t++;
      end
      for (int k = 0; k < lat; k++) begin
        e_busy[t] = 1; t++;
      end
      e_busy[t] = 1; e_we[t] = 1; e_oaddr[t] = n; t++;
    end
    e_busy[t] = 1; e_done[t] = 1;
    return t > MAXC - 100 ? -1 : t;
  endfunction

  task automatic fill_iv(input int stall_at, input int len, input int pct, input int repulse);
    for (int c = 0; c < MAXC; c++) begin
      iv[c] = !(stall_at > 0 && c >= stall_at && c < stall_at + len);
      if (pct > 0 && $urandom_range(99) < pct) iv[c] = 0;
      sp[c] = repulse != 0 && (c == 50 || c == 200);
    end
  endtask

  // Entered and left at #1 after a rising edge; start is sampled by the first edge.
  task automatic run_vec(input int s, input int done_at);
    int nin, nout, lat, mdone, first, nacc, nwe, ndone;
    sel = s;
    nin = s != 0 ? 4 : 28;
    nout = s != 0 ? 2 : 10;
    lat = s != 0 ? 1 : 2;
    mdone = model(nin, nout, lat);
    if (done_at < 0) done_at = mdone;
    first = -1; nacc = 0; nwe = 0; ndone = 0;
    set_start(1);
    in_valid = iv[0];
    @(posedge clk);
    #1;
    set_start(0);
    for (int c = 1; c <= mdone + 3; c++) begin
      in_valid = iv[c];
      set_start(sp[c]);
      @(negedge clk);
      cyc = c;
      chk("acc_clr", o_clr, e_clr[c]);
      chk("acc_en", o_acc, e_acc[c]);
      chk("out_we", o_we, e_we[c]);
      chk("done", o_done, e_done[c]);
      chk("busy", o_busy, e_busy[c]);
      if (e_we[c] != 0) chk("out_addr", o_oaddr, e_oaddr[c]);
      if (e_chk[c] != 0) begin
        chk("feat_addr", o_feat, e_feat[c]);
        chk("wgt_addr", o_wgt, e_wgt[c]);
      end
      nacc += o_acc; nwe += o_we; ndone += o_done;
      if (o_done != 0 && first < 0) first = c;
      @(posedge clk);
      #1;
    end
    set_start(0);
    chk("done_cycle", first, done_at);
    chk("acc_en_total", nacc, nin * nout);
    chk("out_we_total", nwe, nout);
    chk("done_pulses", ndone, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_feat"}, o_feat, 0);
    chk({tag, "_wgt"}, o_wgt, 0);
    chk({tag, "_clr"}, o_clr, 0);
    chk({tag, "_acc"}, o_acc, 0);
    chk({tag, "_we"}, o_we, 0);
    chk({tag, "_oaddr"}, o_oaddr, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int nd, nb;
    tbl[0] = '{0, 0, 0, 0, 0, 321};
    tbl[1] = '{0, 140, 3, 0, 0, 324};
    tbl[2] = '{0, 0, 0, 0, 1, 321};
    tbl[3] = '{1, 0, 0, 0, 0, 15};
    tbl[4] = '{1, 3, 2, 0, 0, 17};
    tbl[5] = '{0, 0, 0, 25, 0, -1};
    tbl[6] = '{1, 0, 0, 40, 0, -1};
    tbl[7] = '{0, 0, 0, 60, 1, -1};
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      chk_zero("reset");
    end
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    for (int v = 0; v < 8; v++) begin
      fill_iv(tbl[v].stall_at, tbl[v].stall_len, tbl[v].pct, tbl[v].repulse);
      run_vec(tbl[v].sel, tbl[v].done_at);
    end
    // abort in cycle 100 of a full-rate run
    sel = 0;
    in_valid = 1;
    set_start(1);
    @(posedge clk);
    #1;
    set_start(0);
    for (int c = 1; c < 100; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    cyc = 100;
    chk("pre_abort_busy", o_busy, 1);
    chk("pre_abort_wgt", o_wgt, 86);
    chk("pre_abort_feat", o_feat, 2);
    abort = 1;
    @(posedge clk);
    #1;
    abort = 0;
    @(negedge clk);
    cyc = 101;
    chk_zero("abort");
    nd = 0;
    nb = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      nd += o_done;
      nb += o_busy;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_idle_busy", nb, 0);
    @(posedge clk);
    #1;
    set_start(1);
    abort = 1;
    @(posedge clk);
    #1;
    set_start(0);
    abort = 0;
    @(negedge clk);
    chk("start_abort_busy", o_busy, 0);
    @(posedge clk);
    #1;
    fill_iv(0, 0, 0, 0);
    run_vec(0, 321);
    // asynchronous reset during the write of neuron 7
    in_valid = 1;
    set_start(1);
    @(posedge clk);
    #1;
    set_start(0);
    for (int c = 1; c < 256; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    cyc = 256;
    chk("pre_reset_we", o_we, 1);
    chk("pre_reset_oaddr", o_oaddr, 7);
    #1;
    reset = 0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    run_vec(0, 321);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
